// File: rtl/router_reg_pkt.sv
// router_reg_pkt: packet data-path register for the 1x3 router.
// Captures header, forwards words to dout, skid-buffers on FIFO full.
//
// Ports:
//   clock, resetn           clock and synchronous active-low reset
//   pkt_valid, data_in      input word; pkt_valid low marks the check word
//   fifo_full               selected destination FIFO is full
//   detect_add .. rst_int_reg  one-hot FSM state decodes
//   dout, dout_valid        forwarded word and its one-cycle strobe
//   header_addr             destination select from header byte
//   low_packet_valid        check word received
//   parity_done, err        check complete / check mismatch
//   skid_count              occupied skid entries
//   skid_overflow           sticky: a word was dropped
module router_reg_pkt #(
  parameter int DATA_W     = 8,
  parameter int SKID_DEPTH = 2,
  parameter int CHK_MODE   = 0,
  localparam int PW = $clog2(SKID_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [1:0]        header_addr,
  output logic              low_packet_valid,
  output logic              parity_done,
  output logic              err,
  output logic [CW-1:0]     skid_count,
  output logic              skid_overflow
);

  logic [DATA_W-1:0]     header_byte;
  logic [DATA_W-1:0]     acc;
  logic [DATA_W-1:0]     rchk;
  logic [DATA_W-1:0]     skid_data [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] skid_last;
  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  // last-marked word reached dout on the previous edge
  logic                  last_fwd;

  logic skid_empty;
  logic skid_full;
  logic is_check;
  logic fwd_direct;
  logic push;
  logic drop;
  logic pop;
  logic new_pkt;

  assign skid_count  = wr_ptr - rd_ptr;
  assign skid_empty  = (wr_ptr == rd_ptr);
  assign skid_full   = (skid_count == CW'(SKID_DEPTH));
  assign header_addr = header_byte[1:0];

  assign new_pkt    = detect_add && pkt_valid;
  assign is_check   = ld_state && !pkt_valid;
  // bypass only when nothing is queued, so order is kept
  assign fwd_direct = ld_state && !fifo_full && skid_empty;
  assign push       = ld_state && !fwd_direct && !skid_full;
  assign drop       = ld_state && !fwd_direct && skid_full;
  assign pop        = laf_state && !skid_empty && !fifo_full;

  function automatic logic [DATA_W-1:0] chk_op(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    if (CHK_MODE == 0) return a ^ b;
    else return a + b;
  endfunction

  always_ff @(posedge clock) begin
    if (push) begin
      skid_data[wr_ptr[PW-1:0]] <= data_in;
      skid_last[wr_ptr[PW-1:0]] <= is_check;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_byte      <= '0;
      acc              <= '0;
      rchk             <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      last_fwd         <= 1'b0;
      dout             <= '0;
      dout_valid       <= 1'b0;
      low_packet_valid <= 1'b0;
      parity_done      <= 1'b0;
      err              <= 1'b0;
      skid_overflow    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      last_fwd   <= 1'b0;

      if (last_fwd) begin
        parity_done <= 1'b1;
        err         <= (acc != rchk) || skid_overflow;
      end

      if (new_pkt) begin
        header_byte   <= data_in;
        acc           <= '0;
        parity_done   <= 1'b0;
        err           <= 1'b0;
        skid_overflow <= 1'b0;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
      end

      if (lfd_state) begin
        dout       <= header_byte;
        dout_valid <= 1'b1;
        acc        <= chk_op(acc, header_byte);
      end

      if (ld_state && pkt_valid)
        acc <= chk_op(acc, data_in);

      if (is_check)
        rchk <= data_in;

      if (fwd_direct) begin
        dout       <= data_in;
        dout_valid <= 1'b1;
        last_fwd   <= is_check;
      end

      if (push)
        wr_ptr <= wr_ptr + CW'(1);

      if (drop)
        skid_overflow <= 1'b1;

      if (pop) begin
        dout       <= skid_data[rd_ptr[PW-1:0]];
        dout_valid <= 1'b1;
        last_fwd   <= skid_last[rd_ptr[PW-1:0]];
        rd_ptr     <= rd_ptr + CW'(1);
      end

      if (is_check)
        low_packet_valid <= 1'b1;
      else if (rst_int_reg)
        low_packet_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_reg_pkt.sv
// tb_router_reg_pkt: directed bench for router_reg_pkt.
// Two instances (XOR and sum check) share stimulus; a queue model predicts outputs.
module tb_router_reg_pkt;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic       fifo_full = 1'b0;
  logic       detect_add = 1'b0;
  logic       lfd_state = 1'b0;
  logic       ld_state = 1'b0;
  logic       laf_state = 1'b0;
  logic       rst_int_reg = 1'b0;

  logic [7:0] dout0, dout1;
  logic       dv0, dv1;
  logic [1:0] ha0, ha1;
  logic       lpv0, lpv1;
  logic       pd0, pd1;
  logic       err0, err1;
  logic [1:0] sc0, sc1;
  logic       ovf0, ovf1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  router_reg_pkt #(.DATA_W(8), .SKID_DEPTH(2), .CHK_MODE(0)) u0 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state),
    .rst_int_reg(rst_int_reg), .dout(dout0), .dout_valid(dv0),
    .header_addr(ha0), .low_packet_valid(lpv0),
    .parity_done(pd0), .err(err0), .skid_count(sc0),
    .skid_overflow(ovf0)
  );

  router_reg_pkt #(.DATA_W(8), .SKID_DEPTH(2), .CHK_MODE(1)) u1 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state),
    .rst_int_reg(rst_int_reg), .dout(dout1), .dout_valid(dv1),
    .header_addr(ha1), .low_packet_valid(lpv1),
    .parity_done(pd1), .err(err1), .skid_count(sc1),
    .skid_overflow(ovf1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // packet-level model: words seen, queue of pending words, check folded at end
  logic [7:0] words[$];
  logic [8:0] q[$];
  logic [8:0] e;
  logic [7:0] m_dout = '0, m_hdr = '0, m_rchk = '0;
  logic m_dv = 0, m_pd = 0, m_err0 = 0, m_err1 = 0;
  logic m_ovf = 0, m_lpv = 0, m_pend = 0, pend_now = 0;
  bit started = 0;

  function automatic logic [7:0] fold(input int mode);
    logic [7:0] r = '0;
    foreach (words[i]) r = (mode != 0) ? r + words[i] : r ^ words[i];
    return r;
  endfunction

  always @(posedge clock) begin
    if (!resetn) begin
      m_dout = '0; m_hdr = '0; m_rchk = '0;
      m_dv = 0; m_pd = 0; m_err0 = 0; m_err1 = 0;
      m_ovf = 0; m_lpv = 0; m_pend = 0;
      q.delete(); words.delete();
      started = 1;
    end else begin
      pend_now = m_pend;
      m_dv = 0;
      m_pend = 0;
      if (pend_now) begin
        m_pd = 1;
        m_err0 = (fold(0) != m_rchk) || m_ovf;
        m_err1 = (fold(1) != m_rchk) || m_ovf;
      end
      if (detect_add && pkt_valid) begin
        m_hdr = data_in; words.delete(); q.delete();
        m_pd = 0; m_err0 = 0; m_err1 = 0; m_ovf = 0;
      end
      if (lfd_state) begin
        m_dout = m_hdr; m_dv = 1; words.push_back(m_hdr);
      end
      if (ld_state) begin
        if (pkt_valid) words.push_back(data_in);
        else begin m_rchk = data_in; m_lpv = 1; end
        if (!fifo_full && q.size() == 0) begin
          m_dout = data_in; m_dv = 1; m_pend = !pkt_valid;
        end else if (q.size() < 2) q.push_back({!pkt_valid, data_in});
        else m_ovf = 1;
      end
      if (laf_state && !fifo_full && q.size() != 0) begin
        e = q.pop_front();
        m_dout = e[7:0]; m_dv = 1; m_pend = e[8];
      end
      if (rst_int_reg) m_lpv = 0;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("dout0", dout0, m_dout);
      chk("dv0", dv0, m_dv);
      chk("ha0", ha0, m_hdr[1:0]);
      chk("lpv0", lpv0, m_lpv);
      chk("pd0", pd0, m_pd);
      chk("err0", err0, m_err0);
      chk("sc0", sc0, q.size());
      chk("ovf0", ovf0, m_ovf);
      chk("dout1", dout1, m_dout);
      chk("pd1", pd1, m_pd);
      chk("err1", err1, m_err1);
      chk("sc1", sc1, q.size());
    end
  end

  // st: 0 idle, 1 detect_add, 2 lfd, 3 ld, 4 laf, 5 rst_int_reg
  task automatic drive(input int st, input logic pv,
                       input logic [7:0] d, input logic ff);
    detect_add  = (st == 1);
    lfd_state   = (st == 2);
    ld_state    = (st == 3);
    laf_state   = (st == 4);
    rst_int_reg = (st == 5);
    pkt_valid   = pv;
    data_in     = d;
    fifo_full   = ff;
    @(posedge clock);
    #1;
  endtask

  task automatic simple_pkt(input logic [7:0] h, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] c,
                            input int np);
    drive(1, 1, h, 0);
    drive(2, 1, 8'h00, 0);
    drive(3, 1, p1, 0);
    if (np > 1) drive(3, 1, p2, 0);
    drive(3, 0, c, 0);
    drive(5, 0, 8'h00, 0);
  endtask

  initial begin
    resetn = 0;
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    chk("lit_rst_dout", dout0, 8'h00);
    chk("lit_rst_sc", sc0, 2'd0);
    resetn = 1;

    // XOR packet, good check
    drive(1, 1, 8'h05, 0);
    chk("lit_haddr", ha0, 2'd1);
    drive(2, 1, 8'h00, 0);
    chk("lit_hdr_out", dout0, 8'h05);
    chk("lit_hdr_dv", dv0, 1'b1);
    drive(3, 1, 8'h11, 0);
    chk("lit_p1", dout0, 8'h11);
    drive(3, 1, 8'h22, 0);
    chk("lit_p2", dout0, 8'h22);
    drive(3, 0, 8'h36, 0);
    chk("lit_chk_out", dout0, 8'h36);
    chk("lit_lpv", lpv0, 1'b1);
    chk("lit_pd_early", pd0, 1'b0);
    drive(5, 0, 8'h00, 0);
    chk("lit_pd", pd0, 1'b1);
    chk("lit_err_ok", err0, 1'b0);
    drive(0, 0, 8'h00, 0);

    // bad check word
    simple_pkt(8'h05, 8'h11, 8'h22, 8'h37, 2);
    chk("lit_err_bad", err0, 1'b1);
    drive(0, 0, 8'h00, 0);

    // sum check wraps: F0+20 = 10
    simple_pkt(8'hF0, 8'h20, 8'h00, 8'h10, 1);
    chk("lit_err_clr", err0, 1'b1);
    chk("lit_sum_ok", err1, 1'b0);
    drive(1, 1, 8'hF0, 0);
    chk("lit_err_clr1", err1, 1'b0);
    drive(2, 1, 8'h00, 0);
    drive(3, 1, 8'h20, 0);
    drive(3, 0, 8'h11, 0);
    drive(5, 0, 8'h00, 0);
    chk("lit_sum_bad", err1, 1'b1);

    // skid: two words held incl. check word, drain in laf
    drive(1, 1, 8'h0A, 0);
    drive(2, 1, 8'h00, 0);
    drive(3, 1, 8'h41, 0);
    drive(3, 1, 8'h42, 1);
    drive(3, 0, 8'h09, 1);
    chk("lit_sc2", sc0, 2'd2);
    drive(4, 0, 8'h00, 1);
    chk("lit_stall_dv", dv0, 1'b0);
    drive(4, 0, 8'h00, 0);
    chk("lit_drain1", dout0, 8'h42);
    drive(4, 0, 8'h00, 0);
    chk("lit_drain2", dout0, 8'h09);
    chk("lit_pd_wait", pd0, 1'b0);
    drive(0, 0, 8'h00, 0);
    chk("lit_pd_drain", pd0, 1'b1);
    chk("lit_err_drain", err0, 1'b0);

    // overflow: third held word dropped
    drive(1, 1, 8'h03, 0);
    drive(2, 1, 8'h00, 0);
    drive(3, 1, 8'h51, 1);
    drive(3, 1, 8'h52, 1);
    drive(3, 1, 8'h53, 1);
    chk("lit_ovf", ovf0, 1'b1);
    drive(4, 0, 8'h00, 0);
    drive(4, 0, 8'h00, 0);
    drive(3, 0, 8'h53, 0);
    drive(5, 0, 8'h00, 0);
    chk("lit_ovf_pd", pd0, 1'b1);
    chk("lit_ovf_err", err0, 1'b1);

    // reset mid-payload
    drive(1, 1, 8'h07, 0);
    drive(2, 1, 8'h00, 0);
    drive(3, 1, 8'h61, 1);
    chk("lit_sc1", sc0, 2'd1);
    resetn = 0;
    drive(0, 0, 8'h00, 0);
    chk("lit_mr_sc", sc0, 2'd0);
    chk("lit_mr_dv", dv0, 1'b0);
    chk("lit_mr_dout", dout0, 8'h00);
    chk("lit_mr_ha", ha0, 2'd0);
    resetn = 1;
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/router_reg_pkt.md
# router_reg_pkt

Parametrised packet data-path register for the 1x3 router: sits between the input port and the destination FIFOs, under control of the router FSM. It captures the header and forwards header, payload and check word to `dout`. A SKID_DEPTH-entry skid buffer absorbs words that arrive while the destination FIFO is full. It also accumulates a selectable check (XOR parity or modular-sum checksum) and flags mismatches against the received check word.

## Interface
- DATA_W, 8: word width of data_in/dout and of the check accumulator.
- SKID_DEPTH, 2: skid buffer entries (power of two, >=2).
- CHK_MODE, 0: 0 = XOR parity; 1 = sum modulo 2^DATA_W.
- clock  in  1  clock, all logic on posedge.
- resetn  in  1  reset, synchronous, active-low.
- pkt_valid  in  1  high for header/payload words; low on the check word.
- data_in  in  DATA_W  input word.
- fifo_full  in  1  selected destination FIFO full.
- detect_add, lfd_state, ld_state, laf_state, rst_int_reg  in  1 each  FSM state decodes (one-hot, at most one high).
- dout  out  DATA_W  word to destination FIFO.
- dout_valid  out  1  one-cycle strobe: dout updated this cycle.
- header_addr  out  2  header_byte[1:0], destination select.
- low_packet_valid  out  1  check word received.
- parity_done  out  1  check word forwarded; err valid.
- err  out  1  check mismatch for current packet.
- skid_count  out  clog2(SKID_DEPTH)+1  occupied skid entries.
- skid_overflow  out  1  sticky: word dropped, skid full.

## Operation
- Reset: all outputs, header_byte, accumulator, received-check register, skid pointers = 0.
- detect_add && pkt_valid: header_byte <= data_in; accumulator <= 0; parity_done, err, skid_overflow <= 0; skid flushed.
- lfd_state: dout <= header_byte, dout_valid = 1; accumulator <= acc OP header_byte.
- ld_state, pkt_valid=1 (payload): accumulator <= acc OP data_in.
- ld_state, pkt_valid=0 (check word): received-check <= data_in; low_packet_valid <= 1; the word is forwarded like payload and marked last.
- Forward rule (ld_state): if ~fifo_full and skid empty, dout <= data_in, dout_valid=1. Otherwise push data_in to skid. If the skid is full, drop the word and set skid_overflow.
- laf_state: if skid non-empty and ~fifo_full, dout <= skid head, dout_valid=1, pop. The head is popped before any ld_state push in later cycles; order is preserved.
- OP: XOR (CHK_MODE=0) or add, wrap to DATA_W bits (CHK_MODE=1). The header is included; the check word is excluded.
- parity_done <= 1 in the cycle after the last-marked word is written to dout, whether directly or from the skid. It holds until the next detect_add.
- err <= (accumulator != received-check), updated in the same edge parity_done sets. It is also forced to 1 if skid_overflow is set. It holds until the next header.
- rst_int_reg: low_packet_valid <= 0. A set in the same cycle wins.

## Timing
- All outputs registered; data_in to dout latency 1 cycle when FIFO not full.
- Skid drain: one word per cycle while laf_state && ~fifo_full.
- Check word to parity_done: 2 cycles with FIFO not full; 2 + stall cycles otherwise.
- skid_count changes at most by 1 per cycle; a push and a pop in the same cycle leave it unchanged.
- Reset mid-packet: next edge returns everything to reset values, skid empty, no dout_valid.

## Test plan
- Packet header 0x05, payload 0x11 0x22, check 0x36, CHK_MODE=0, FIFO never full -> dout 0x05,0x11,0x22,0x36 on successive strobes; parity_done 2 cycles after check; err=0.
- Same packet with check 0x37 -> err=1 alongside parity_done; cleared at next detect_add.
- CHK_MODE=1, header 0xF0, payload 0x20, check 0x10 -> err=0 (sum wraps); check 0x11 -> err=1.
- fifo_full asserted for 2 words during ld_state, SKID_DEPTH=2 -> skid_count reaches 2. Words drain in order in laf_state after fifo_full drops; parity_done only after the drain.
- fifo_full held for 3 pushes -> third word dropped, skid_overflow=1, err=1 at parity_done.
- resetn low mid-payload with 1 skid entry -> all outputs 0, skid_count 0 next cycle.
